// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared 640x480@60 VGA timing constants
// Purpose: default horizontal/vertical geometry, derived totals and sync
//          window bounds, shared by the sync generator, the RGB selector
//          and the glyph generators for region bounds.
// Ports:   none (package).
package vga_timing_pkg;

  // Coordinate width; 10 bits covers any total up to 1024.
  localparam int COORD_W = 10;

  localparam int H_DISPLAY = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int V_DISPLAY = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  // Inclusive sync windows.
  localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_DISPLAY + V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  // True when v lies in the inclusive window [lo, hi].
  function automatic logic in_window(input logic [COORD_W-1:0] v,
                                     input logic [COORD_W-1:0] lo,
                                     input logic [COORD_W-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_pixel_tick.sv
// rtl/vga_pixel_tick.sv - system clock to pixel enable divider
// Purpose: counts 0..CLK_DIV-1 and decodes a one-clock pixel enable from
//          the registered count (high when the count sits at CLK_DIV-1).
// Ports:   clk_i   - system clock
//          rst_ni  - asynchronous active-low reset
//          tick_o  - pixel enable, one clk_i every CLK_DIV clocks
module vga_pixel_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);

  localparam int                W    = $clog2(CLK_DIV);
  localparam logic [W-1:0]      LAST = W'(CLK_DIV - 1);

  logic [W-1:0] div_q;
  logic [W-1:0] div_d;

  always_comb begin
    div_d = div_q + W'(1);
    if (div_q == LAST) begin
      div_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  assign tick_o = (div_q == LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA horizontal/vertical counters and sync generation
// Purpose: runs the pixel/line counters on the pixel enable and produces
//          registered active-low syncs aligned with the coordinates, the
//          visible-area flag and a one-clock end-of-frame strobe.
// Ports:   clk       - system clock
//          reset     - asynchronous active-low reset
//          p_tick    - pixel enable
//          pix_x     - horizontal counter, 0..H_TOTAL-1
//          pix_y     - vertical counter, 0..V_TOTAL-1
//          video_on  - high inside the visible area
//          hsync     - horizontal sync, active-low
//          vsync     - vertical sync, active-low
//          frame_end - strobe on the final pixel of the frame
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = vga_timing_pkg::H_DISPLAY,
  parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int H_BACK    = vga_timing_pkg::H_BACK,
  parameter int V_DISPLAY = vga_timing_pkg::V_DISPLAY,
  parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int V_BACK    = vga_timing_pkg::V_BACK
) (
  input  logic               clk,
  input  logic               reset,
  output logic               p_tick,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               video_on,
  output logic               hsync,
  output logic               vsync,
  output logic               frame_end
);

  localparam int H_TOT = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOT = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOT - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOT - 1);
  localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_DISPLAY);
  localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_DISPLAY);
  localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_DISPLAY + H_FRONT);
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_DISPLAY + V_FRONT);
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic               tick;
  logic               line_end;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;

  vga_pixel_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_pixel_tick (
    .clk_i  (clk),
    .rst_ni (reset),
    .tick_o (tick)
  );

  assign line_end = (x_q == H_LAST);

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (tick) begin
      if (line_end) begin
        x_d = '0;
        if (y_q == V_LAST) begin
          y_d = '0;
        end else begin
          y_d = y_q + COORD_W'(1);
        end
      end else begin
        x_d = x_q + COORD_W'(1);
      end
    end
  end

  // Syncs decode the next-state coordinates so they switch on the same
  // edge as the counters instead of one pixel late.
  always_comb begin
    hsync_d = !in_window(x_d, HS_START, HS_END);
    vsync_d = !in_window(y_d, VS_START, VS_END);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q     <= '0;
      y_q     <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign p_tick    = tick;
  assign pix_x     = x_q;
  assign pix_y     = y_q;
  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign video_on  = (x_q < H_VIS) && (y_q < V_VIS);
  assign frame_end = tick && line_end && (y_q == V_LAST);

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - self-checking bench for vga_sync_gen
module tb_vga_sync_gen;

  localparam int D  = 4;
  localparam int HD = 20, HF = 3, HS = 5, HB = 4;
  localparam int VD = 6,  VF = 2, VS = 2, VB = 3;
  localparam int HT = HD + HF + HS + HB;   // 32
  localparam int VT = VD + VF + VS + VB;   // 13

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       p_tick, video_on, hsync, vsync, frame_end;
  logic [9:0] pix_x, pix_y;

  int total = 0;
  int bad   = 0;

  longint k = 0;          // rising edges taken since reset release
  int     h_run = 0;
  int     v_run = 0;
  longint last_fe = -1;
  int     fe_count = 0;

  vga_sync_gen #(
    .CLK_DIV(D),
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .p_tick    (p_tick),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .video_on  (video_on),
    .hsync     (hsync),
    .vsync     (vsync),
    .frame_end (frame_end)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      if (bad <= 30)
        $display("FAIL %s actual=%0d required=%0d (t=%0t k=%0d)", name, act, exp, $time, k);
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) k <= 0;
    else        k <= k + 1;
  end

  // Reference: the outputs are a pure function of the elapsed clocks.
  always @(negedge clk) begin
    longint pk, ex, ey;
    logic   e_tick, e_hs, e_vs, e_von, e_fe;
    pk     = k / D;
    ex     = pk % HT;
    ey     = (pk / HT) % VT;
    e_tick = (k % D) == D - 1;
    e_hs   = !(ex >= HD + HF && ex < HD + HF + HS);
    e_vs   = !(ey >= VD + VF && ey < VD + VF + VS);
    e_von  = (ex < HD) && (ey < VD);
    e_fe   = e_tick && ex == HT - 1 && ey == VT - 1;
    chk("pix_x", pix_x, ex);
    chk("pix_y", pix_y, ey);
    chk("p_tick", p_tick, e_tick);
    chk("hsync", hsync, e_hs);
    chk("vsync", vsync, e_vs);
    chk("video_on", video_on, e_von);
    chk("frame_end", frame_end, e_fe);

    if (!reset) begin
      h_run = 0; v_run = 0; last_fe = -1; fe_count = 0;
    end else begin
      if (!hsync) h_run++;
      else if (h_run > 0) begin
        chk("hsync_low_clocks", h_run, 20);
        h_run = 0;
      end
      if (!vsync) v_run++;
      else if (v_run > 0) begin
        chk("vsync_low_clocks", v_run, 256);
        v_run = 0;
      end
      if (frame_end) begin
        fe_count++;
        if (last_fe >= 0) chk("frame_period", k - last_fe, 1664);
        last_fe = k;
      end
    end
  end

  task automatic chk_reset_state(input string tag);
    chk({tag, "_x"}, pix_x, 0);
    chk({tag, "_y"}, pix_y, 0);
    chk({tag, "_hs"}, hsync, 1);
    chk({tag, "_vs"}, vsync, 1);
    chk({tag, "_tick"}, p_tick, 0);
    chk({tag, "_fe"}, frame_end, 0);
    chk({tag, "_von"}, video_on, 1);
  endtask

  // Offsets within the 10-unit period that avoid both clock edges.
  function automatic int pick_offset();
    int o;
    o = $urandom_range(0, 5);
    return (o < 3) ? o + 1 : o + 3;
  endfunction

  initial begin
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk_reset_state("rst0");
    @(posedge clk);
    #2 reset = 1'b1;

    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      if (i == 3) begin
        chk("start_tick3", p_tick, 1);
        chk("start_x3", pix_x, 0);
      end
      if (i == 4) begin
        chk("start_x4", pix_x, 1);
        chk("start_tick4", p_tick, 0);
      end
      if (i == 7) chk("start_tick7", p_tick, 1);
      if (i == 8) begin
        chk("start_x8", pix_x, 2);
        chk("start_hs8", hsync, 1);
        chk("start_vs8", vsync, 1);
        chk("start_von8", video_on, 1);
      end
    end

    repeat (3 * 1664 + 50 - 8) @(posedge clk);
    #1;
    chk("frames_seen", fe_count, 3);

    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(50, 2000)) @(posedge clk);
      #(pick_offset());
      reset = 1'b0;
      #1;
      chk_reset_state("async_rst");
      repeat ($urandom_range(0, 3)) @(posedge clk);
      @(posedge clk);
      #(pick_offset());
      reset = 1'b1;
    end
    repeat (1800) @(posedge clk);
    #1;
    chk("frames_after_resets", fe_count >= 1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Generates 640x480@60 Hz VGA timing for the display path. Divides the 100 MHz system clock into a 25 MHz pixel enable and runs the horizontal and vertical counters. Produces `hsync`, `vsync`, `video_on` and the `pix_x`/`pix_y` coordinates consumed by the RGB selector and the number, letter and ring generators. It also emits a one-clock end-of-frame strobe, which lets the RTC display logic update registers outside the visible area.

## Interface
- `CLK_DIV`, 4: system clocks per pixel; must be ≥2.
- `H_DISPLAY`, 640: visible pixels per line.
- `H_FRONT`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: horizontal sync width, in pixels.
- `H_BACK`, 48: horizontal back porch, in pixels.
- `V_DISPLAY`, 480: visible lines per frame.
- `V_FRONT`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vertical sync width, in lines.
- `V_BACK`, 33: vertical back porch, in lines.
- `clk` in 1: system clock, 100 MHz.
- `reset` in 1: asynchronous, active-low reset.
- `p_tick` out 1: pixel enable, high for one `clk` every `CLK_DIV` clocks.
- `pix_x` out 10: horizontal counter, range 0..H_TOTAL-1.
- `pix_y` out 10: vertical counter, range 0..V_TOTAL-1.
- `video_on` out 1: high when `pix_x` < H_DISPLAY and `pix_y` < V_DISPLAY.
- `hsync` out 1: horizontal sync, active-low.
- `vsync` out 1: vertical sync, active-low.
- `frame_end` out 1: one-`clk` strobe on the final pixel of the frame.

## Operation
- Derived constants: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525).
- Divider:
  - `div_cnt` counts 0..CLK_DIV-1 and wraps to 0.
  - `p_tick` = (`div_cnt` == CLK_DIV-1), decoded from the register.
- Horizontal counter:
  - Advances only on `p_tick`.
  - At H_TOTAL-1 it wraps to 0 and produces a line-end condition.
- Vertical counter:
  - Advances only on `p_tick` with line-end.
  - At V_TOTAL-1, with line-end, it wraps to 0.
- `pix_x` and `pix_y` are the counter registers themselves.
- `video_on` is combinational from the registered counters.
- `hsync`:
  - Registered.
  - Low while `pix_x` is in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1] = [656, 751].
  - Computed from the next-state counter value, so it changes on the same edge as `pix_x`.
- `vsync`:
  - Registered.
  - Low while `pix_y` is in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1] = [490, 491].
  - Computed from the next-state counter value, so it changes on the same edge as `pix_y`.
- `frame_end` = `p_tick` && `pix_x` == H_TOTAL-1 && `pix_y` == V_TOTAL-1.
- There is no other state machine. Counter wrap-around is the only mode transition.

## Timing
- Reset (`reset` low, asynchronous), all outputs take these values immediately:
  - `div_cnt`=0, `pix_x`=0, `pix_y`=0
  - `hsync`=1, `vsync`=1
  - `p_tick`=0, `frame_end`=0
  - `video_on`=1 (derived from counters at 0,0)
- Reset release is sampled on the next `clk` rising edge.
- `p_tick` is first high after the 3rd rising edge following release. `pix_x` becomes 1 on the 4th edge.
- Each pixel lasts exactly CLK_DIV clocks.
- Line period = 800×4 = 3200 clocks. Frame period = 525×3200 = 1,680,000 clocks.
- Sync and coordinates share zero relative latency: `hsync` falls on the edge where `pix_x` becomes 656 and rises on the edge where `pix_x` becomes 752.
- Simultaneous horizontal and vertical wrap: on the final pixel, both counters return to 0 on the same edge. `vsync` and `hsync` are both 1 after that edge.
- Reset asserted mid-frame aborts immediately with no partial-line completion. The first line after reset is a full line.
- Widths: 10-bit counters suffice because H_TOTAL ≤ 1024. `div_cnt` width = clog2(CLK_DIV).

## Structure
- Shared package `vga_timing_pkg`: the H_*/V_* defaults, H_TOTAL, V_TOTAL, and sync start/end constants. The RGB selector and the glyph generators reuse the same package for region bounds.
- Sub-module `vga_pixel_tick`: a parameterised divider producing `p_tick`. It is instantiated once.
- Counter and sync logic stay in `vga_sync_gen`.

## Test plan
- Reset release, then run 8 clocks → `p_tick` is high on clocks 4 and 8 only; `pix_x` steps 0→1→2; `hsync`=`vsync`=1; `video_on`=1.
- Run one line → `video_on` falls when `pix_x` goes 639→640; `hsync` is low for exactly 96×4 = 384 clocks starting at `pix_x`=656; `pix_x` wraps 799→0 and `pix_y` goes 0→1 on the same edge.
- Run one frame → `vsync` is low exactly while `pix_y`∈{490,491} (6400 clocks); `frame_end` pulses once, 1,680,000 clocks after the first pixel; both counters return to 0.
- Pulse `reset` low for 1 clock at `pix_x`=300, `pix_y`=200 → outputs reset asynchronously before the next edge; the restart matches scenario 1.
- Compile with CLK_DIV=2 → `p_tick` toggles every other clock; line period = 1600 clocks.
- Continuous 3 frames → the period between `frame_end` pulses is constant at 1,680,000 clocks; no `hsync` glitch across the frame boundary.
